pc_seq_unit: RTL and testbench

Parametrised program-counter unit for micro_mips; successor to the fixed 32-bit/256-entry PC table.
Holds the current PC and advances it by mode each enabled cycle: sequential, relative branch, absolute jump, indexed lookup in a preloaded address table, or call/return through a return-address stack (RAS).
Table is loaded serially before or between runs.
Output feeds the instruction-fetch address.

---
 rtl/pc_seq_unit.sv | 121 ++++++++++++
 tb/tb_pc_seq_unit.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/pc_seq_unit.sv
// Program-counter unit: SEQ/BRANCH/JUMP/TABLE/CALL/RET with a serially loaded address table and circular RAS.
// Latency: the new PC appears on out one cycle after en/mode are presented; table writes are readable the next cycle.
// Backpressure: none; a load into a full table is dropped and flagged on err.
module pc_seq_unit #(
    parameter int ADDR_W = 32,
    parameter int DEPTH = 256,
    parameter int RAS_DEPTH = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic                     clk,
    input  logic                     res,
    input  logic                     ld_en,
    input  logic [ADDR_W-1:0]        ld_data,
    input  logic                     en,
    input  logic [2:0]               mode,
    input  logic [$clog2(DEPTH)-1:0] idx,
    input  logic [ADDR_W-1:0]        offset,
    input  logic [ADDR_W-1:0]        target,
    output logic [ADDR_W-1:0]        out,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     ld_full,
    output logic                     ras_empty,
    output logic                     ras_full,
    output logic                     err
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = IDX_W + 1;
    localparam int RP_W  = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
    localparam int OCC_W = $clog2(RAS_DEPTH + 1);

    localparam logic [2:0] M_SEQ    = 3'd0;
    localparam logic [2:0] M_BRANCH = 3'd1;
    localparam logic [2:0] M_JUMP   = 3'd2;
    localparam logic [2:0] M_TABLE  = 3'd3;
    localparam logic [2:0] M_CALL   = 3'd4;
    localparam logic [2:0] M_RET    = 3'd5;

    logic [ADDR_W-1:0] tbl [DEPTH];
    logic [ADDR_W-1:0] ras [RAS_DEPTH];
    logic [RP_W-1:0]   sp;
    logic [OCC_W-1:0]  occ;

    logic [RP_W-1:0]   sp_inc;
    logic [RP_W-1:0]   sp_dec;
    logic [ADDR_W-1:0] ras_top;
    logic [ADDR_W-1:0] pc_plus4;
    logic              tbl_full;

    // sp is the next free slot; once full it also points at the oldest entry, which a push overwrites.
    always_comb begin
        sp_inc   = (sp == RP_W'(RAS_DEPTH - 1)) ? '0 : sp + RP_W'(1);
        sp_dec   = (sp == '0) ? RP_W'(RAS_DEPTH - 1) : sp - RP_W'(1);
        ras_top  = ras[sp_dec];
        pc_plus4 = out + ADDR_W'(4);
        tbl_full = (count == CNT_W'(DEPTH));
    end

    assign ld_full   = tbl_full;
    assign ras_empty = (occ == '0);
    assign ras_full  = (occ == OCC_W'(RAS_DEPTH));

    always_ff @(posedge clk) begin
        if (!res && ld_en && !tbl_full)
            tbl[count[IDX_W-1:0]] <= ld_data;
    end

    always_ff @(posedge clk) begin
        if (res) begin
            out   <= RESET_PC;
            count <= '0;
            sp    <= '0;
            occ   <= '0;
            err   <= 1'b0;
        end else begin
            err <= 1'b0;
            if (ld_en) begin
                if (tbl_full)
                    err <= 1'b1;
                else
                    count <= count + CNT_W'(1);
            end else if (en) begin
                case (mode)
                    M_SEQ:    out <= pc_plus4;
                    M_BRANCH: out <= pc_plus4 + (offset << 2);
                    M_JUMP:   out <= target;
                    M_TABLE: begin
                        if ({1'b0, idx} < count) begin
                            out <= tbl[idx];
                        end else if (count != '0) begin
                            out <= tbl[0];
                            err <= 1'b1;
                        end else begin
                            out <= RESET_PC;
                            err <= 1'b1;
                        end
                    end
                    M_CALL: begin
                        ras[sp] <= pc_plus4;
                        sp      <= sp_inc;
                        if (!ras_full)
                            occ <= occ + OCC_W'(1);
                        out <= target;
                    end
                    M_RET: begin
                        if (!ras_empty) begin
                            out <= ras_top;
                            sp  <= sp_dec;
                            occ <= occ - OCC_W'(1);
                        end else begin
                            out <= RESET_PC;
                            err <= 1'b1;
                        end
                    end
                    default: err <= 1'b1;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_pc_seq_unit.sv
// Directed vector bench for pc_seq_unit with a 4-entry table and 4-entry RAS.
module tb_pc_seq_unit;

    localparam int ADDR_W = 32;
    localparam int DEPTH = 4;
    localparam int RAS_DEPTH = 4;

    localparam logic [2:0] SEQ = 3'd0, BR = 3'd1, JMP = 3'd2, TBL = 3'd3, CALL = 3'd4, RET = 3'd5;

    logic              clk = 1'b0;
    logic              res, ld_en, en;
    logic [ADDR_W-1:0] ld_data, offset, target;
    logic [2:0]        mode;
    logic [1:0]        idx;
    logic [ADDR_W-1:0] out;
    logic [2:0]        count;
    logic              ld_full, ras_empty, ras_full, err;

    always #5 clk = ~clk;

    pc_seq_unit #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .RAS_DEPTH(RAS_DEPTH), .RESET_PC(32'h0)) dut (
        .clk(clk), .res(res), .ld_en(ld_en), .ld_data(ld_data), .en(en), .mode(mode),
        .idx(idx), .offset(offset), .target(target), .out(out), .count(count),
        .ld_full(ld_full), .ras_empty(ras_empty), .ras_full(ras_full), .err(err)
    );

    typedef struct {
        string       name;
        logic        res;
        logic        ld;
        logic [31:0] ldd;
        logic        en;
        logic [2:0]  mode;
        logic [1:0]  idx;
        logic [31:0] off;
        logic [31:0] tgt;
        logic [38:0] exp;
    } vec_t;

    vec_t vq[$];
    int   n_vec = 0;
    int   n_bad = 0;

    function automatic vec_t V(string name, logic r, logic l, logic [31:0] ldd, logic e, logic [2:0] m,
                               logic [1:0] i, logic [31:0] o, logic [31:0] t, logic [31:0] eout,
                               logic [2:0] ecnt, logic eerr, logic eempty, logic efull, logic elf);
        vec_t v;
        v.name = name; v.res = r; v.ld = l; v.ldd = ldd; v.en = e; v.mode = m;
        v.idx = i; v.off = o; v.tgt = t;
        v.exp = {eout, ecnt, eerr, eempty, efull, elf};
        return v;
    endfunction

    task automatic drive(logic r, logic l, logic [31:0] ldd, logic e, logic [2:0] m,
                         logic [1:0] i, logic [31:0] o, logic [31:0] t);
        @(negedge clk);
        res = r; ld_en = l; ld_data = ldd; en = e; mode = m; idx = i; offset = o; target = t;
        @(posedge clk);
        #1;
    endtask

    task automatic check(string name, logic [38:0] act, logic [38:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got {out,count,err,ras_empty,ras_full,ld_full}=%h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic [38:0] snap();
        return {out, count, err, ras_empty, ras_full, ld_full};
    endfunction

    initial begin
        res = 1'b0; ld_en = 1'b0; ld_data = '0; en = 1'b0; mode = SEQ; idx = '0; offset = '0; target = '0;

        //             name         res ld ldd          en mode idx off          tgt          out          cnt err emp ful lf
        vq.push_back(V("reset",     1, 0, 0,           0, SEQ, 0, 0,           0,           32'h0,       0, 0, 1, 0, 0));
        vq.push_back(V("seq1",      0, 0, 0,           1, SEQ, 0, 0,           0,           32'h4,       0, 0, 1, 0, 0));
        vq.push_back(V("seq2",      0, 0, 0,           1, SEQ, 0, 0,           0,           32'h8,       0, 0, 1, 0, 0));
        vq.push_back(V("seq3",      0, 0, 0,           1, SEQ, 0, 0,           0,           32'hC,       0, 0, 1, 0, 0));
        vq.push_back(V("res_mid",   1, 0, 0,           1, SEQ, 0, 0,           0,           32'h0,       0, 0, 1, 0, 0));
        vq.push_back(V("jmp80",     0, 0, 0,           1, JMP, 0, 0,           32'h80,      32'h80,      0, 0, 1, 0, 0));
        vq.push_back(V("tbl_empty", 0, 0, 0,           1, TBL, 0, 0,           0,           32'h0,       0, 1, 1, 0, 0));
        vq.push_back(V("idle",      0, 0, 0,           0, TBL, 0, 0,           0,           32'h0,       0, 0, 1, 0, 0));
        vq.push_back(V("ld0",       0, 1, 32'h100,     1, SEQ, 0, 0,           0,           32'h0,       1, 0, 1, 0, 0));
        vq.push_back(V("ld1",       0, 1, 32'h200,     1, SEQ, 0, 0,           0,           32'h0,       2, 0, 1, 0, 0));
        vq.push_back(V("ld2",       0, 1, 32'h300,     1, SEQ, 0, 0,           0,           32'h0,       3, 0, 1, 0, 0));
        vq.push_back(V("tbl_i2",    0, 0, 0,           1, TBL, 2, 0,           0,           32'h300,     3, 0, 1, 0, 0));
        vq.push_back(V("tbl_oob",   0, 0, 0,           1, TBL, 3, 0,           0,           32'h100,     3, 1, 1, 0, 0));
        vq.push_back(V("tbl_i1",    0, 0, 0,           1, TBL, 1, 0,           0,           32'h200,     3, 0, 1, 0, 0));
        vq.push_back(V("ld3_en",    0, 1, 32'h400,     1, JMP, 0, 0,           32'h999,     32'h200,     4, 0, 1, 0, 1));
        vq.push_back(V("tbl_new",   0, 0, 0,           1, TBL, 3, 0,           0,           32'h400,     4, 0, 1, 0, 1));
        vq.push_back(V("ld_over",   0, 1, 32'h500,     0, SEQ, 0, 0,           0,           32'h400,     4, 1, 1, 0, 1));
        vq.push_back(V("tbl_keep",  0, 0, 0,           1, TBL, 3, 0,           0,           32'h400,     4, 0, 1, 0, 1));
        vq.push_back(V("jmp40",     0, 0, 0,           1, JMP, 0, 0,           32'h40,      32'h40,      4, 0, 1, 0, 1));
        vq.push_back(V("br_neg",    0, 0, 0,           1, BR,  0, 32'hFFFFFFFE, 0,          32'h3C,      4, 0, 1, 0, 1));
        vq.push_back(V("br_pos",    0, 0, 0,           1, BR,  0, 32'h3,       0,           32'h4C,      4, 0, 1, 0, 1));
        vq.push_back(V("br_shlost", 0, 0, 0,           1, BR,  0, 32'h40000001, 0,          32'h54,      4, 0, 1, 0, 1));
        vq.push_back(V("jmp_top",   0, 0, 0,           1, JMP, 0, 0,           32'hFFFFFFFC, 32'hFFFFFFFC, 4, 0, 1, 0, 1));
        vq.push_back(V("seq_wrap",  0, 0, 0,           1, SEQ, 0, 0,           0,           32'h0,       4, 0, 1, 0, 1));
        vq.push_back(V("jmp1230",   0, 0, 0,           1, JMP, 0, 0,           32'h1230,    32'h1230,    4, 0, 1, 0, 1));
        vq.push_back(V("mode6",     0, 0, 0,           1, 3'd6, 0, 0,          32'h77,      32'h1230,    4, 1, 1, 0, 1));
        vq.push_back(V("mode6_off", 0, 0, 0,           0, 3'd6, 0, 0,          32'h77,      32'h1230,    4, 0, 1, 0, 1));
        vq.push_back(V("mode7",     0, 0, 0,           1, 3'd7, 0, 0,          32'h77,      32'h1230,    4, 1, 1, 0, 1));
        vq.push_back(V("jmp10",     0, 0, 0,           1, JMP, 0, 0,           32'h10,      32'h10,      4, 0, 1, 0, 1));
        vq.push_back(V("call1",     0, 0, 0,           1, CALL, 0, 0,          32'h20,      32'h20,      4, 0, 0, 0, 1));
        vq.push_back(V("call2",     0, 0, 0,           1, CALL, 0, 0,          32'h30,      32'h30,      4, 0, 0, 0, 1));
        vq.push_back(V("call3",     0, 0, 0,           1, CALL, 0, 0,          32'h40,      32'h40,      4, 0, 0, 0, 1));
        vq.push_back(V("call4",     0, 0, 0,           1, CALL, 0, 0,          32'h50,      32'h50,      4, 0, 0, 1, 1));
        vq.push_back(V("call5",     0, 0, 0,           1, CALL, 0, 0,          32'h60,      32'h60,      4, 0, 0, 1, 1));
        vq.push_back(V("ret1",      0, 0, 0,           1, RET, 0, 0,           0,           32'h54,      4, 0, 0, 0, 1));
        vq.push_back(V("ret2",      0, 0, 0,           1, RET, 0, 0,           0,           32'h44,      4, 0, 0, 0, 1));
        vq.push_back(V("ret3",      0, 0, 0,           1, RET, 0, 0,           0,           32'h34,      4, 0, 0, 0, 1));
        vq.push_back(V("ret4",      0, 0, 0,           1, RET, 0, 0,           0,           32'h24,      4, 0, 1, 0, 1));
        vq.push_back(V("ret_empty", 0, 0, 0,           1, RET, 0, 0,           0,           32'h0,       4, 1, 1, 0, 1));
        vq.push_back(V("res_tbl",   1, 0, 0,           1, JMP, 0, 0,           32'h44,      32'h0,       0, 0, 1, 0, 0));
        vq.push_back(V("jmp80b",    0, 0, 0,           1, JMP, 0, 0,           32'h80,      32'h80,      0, 0, 1, 0, 0));
        vq.push_back(V("tbl_after", 0, 0, 0,           1, TBL, 0, 0,           0,           32'h0,       0, 1, 1, 0, 0));
        vq.push_back(V("call_a",    0, 0, 0,           1, CALL, 0, 0,          32'h200,     32'h200,     0, 0, 0, 0, 0));
        vq.push_back(V("res_ras",   1, 0, 0,           1, RET, 0, 0,           0,           32'h0,       0, 0, 1, 0, 0));
        vq.push_back(V("jmp8",      0, 0, 0,           1, JMP, 0, 0,           32'h8,       32'h8,       0, 0, 1, 0, 0));
        vq.push_back(V("ret_clr",   0, 0, 0,           1, RET, 0, 0,           0,           32'h0,       0, 1, 1, 0, 0));
        vq.push_back(V("lda",       0, 1, 32'hA0,      1, SEQ, 0, 0,           0,           32'h0,       1, 0, 1, 0, 0));
        vq.push_back(V("ldb",       0, 1, 32'hB0,      1, SEQ, 0, 0,           0,           32'h0,       2, 0, 1, 0, 0));
        vq.push_back(V("ldc",       0, 1, 32'hC0,      1, SEQ, 0, 0,           0,           32'h0,       3, 0, 1, 0, 0));
        vq.push_back(V("ldd",       0, 1, 32'hD0,      1, SEQ, 0, 0,           0,           32'h0,       4, 0, 1, 0, 1));
        vq.push_back(V("lde_drop",  0, 1, 32'hE0,      1, SEQ, 0, 0,           0,           32'h0,       4, 1, 1, 0, 1));
        vq.push_back(V("tbl_d0",    0, 0, 0,           1, TBL, 3, 0,           0,           32'hD0,      4, 0, 1, 0, 1));

        foreach (vq[k]) begin
            drive(vq[k].res, vq[k].ld, vq[k].ldd, vq[k].en, vq[k].mode, vq[k].idx, vq[k].off, vq[k].tgt);
            check(vq[k].name, snap(), vq[k].exp);
        end

        // Load strobe during a RET: PC and RAS must hold while the dropped load flags err.
        drive(0, 0, 0, 1, CALL, 0, 0, 32'h300);
        check("hs_call", snap(), {32'h300, 3'd4, 1'b0, 1'b0, 1'b0, 1'b1});
        drive(0, 1, 32'hF0, 1, RET, 0, 0, 0);
        check("hs_ld_ret", snap(), {32'h300, 3'd4, 1'b1, 1'b0, 1'b0, 1'b1});
        drive(0, 0, 0, 1, RET, 0, 0, 0);
        check("hs_ret", snap(), {32'hD4, 3'd4, 1'b0, 1'b1, 1'b0, 1'b1});
        drive(0, 0, 0, 0, RET, 0, 0, 0);
        check("hs_hold", snap(), {32'hD4, 3'd4, 1'b0, 1'b1, 1'b0, 1'b1});

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
